axil2mpi_bridge: RTL

AXI4-Lite slave to MPI bridge. It terminates the shell's AXI4-Lite control channel and drives the single-cycle `cpu_wr` / `cpu_rd` register bus consumed by the user-logic register file (`reg_ul_access`). It serialises reads and writes onto the shared `cpu_wr_addr` bus and waits out the register file's registered read latency. Only one MPI access is outstanding at any time.

---
 rtl/axil2mpi_bridge.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/axil2mpi_bridge.sv
// AXI4-Lite slave terminating the shell control channel and driving the single-cycle
// cpu_wr / cpu_rd register bus; one MPI access in flight, round-robin read/write.
module axil2mpi_bridge #(
    parameter int CPU_ADDR_WIDTH = 12,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int RD_WAIT        = 2
) (
    input  logic                      clks,
    input  logic                      reset,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    input  logic [CPU_DATA_WIDTH-1:0] s_wdata,
    input  logic [3:0]                s_wstrb,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    output logic [1:0]                s_bresp,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [CPU_DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      cpu_wr,
    output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
    output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
    output logic                      cpu_rd,
    input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out
);

    localparam logic [2:0] RD_WAIT_L = 3'(RD_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RD    = 3'd3,
        ST_RRESP = 3'd4
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      aw_full_r;
    logic                      w_full_r;
    logic [CPU_ADDR_WIDTH-1:0] aw_addr_r;
    logic [CPU_DATA_WIDTH-1:0] w_data_r;
    logic [3:0]                w_strb_r;
    logic                      last_was_rd_r;
    logic                      err_r;
    logic [2:0]                rd_cnt_r;
    logic                      cpu_wr_r;
    logic                      cpu_rd_r;
    logic                      bvalid_r;
    logic                      rvalid_r;
    logic [1:0]                bresp_r;
    logic [CPU_DATA_WIDTH-1:0] rdata_r;
    logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr_r;
    logic [CPU_DATA_WIDTH-1:0] cpu_data_in_r;
    logic                      wr_win_s;
    logic                      rd_win_s;
    logic                      rd_done_s;
    logic                      idle_s;
    logic                      unused_addr_bits_s;

    // Only the word-address field is decoded; the rest of the byte address aliases.
    assign unused_addr_bits_s = ^{s_awaddr[AXI_ADDR_WIDTH-1:CPU_ADDR_WIDTH+2], s_awaddr[1:0],
                                  s_araddr[AXI_ADDR_WIDTH-1:CPU_ADDR_WIDTH+2], s_araddr[1:0]};

    assign idle_s    = (state_r == ST_IDLE);
    assign rd_done_s = (state_r == ST_RD) && (rd_cnt_r == RD_WAIT_L);

    // Readies are gated by reset so they read 0 while the block is held in reset.
    assign s_awready = !reset && idle_s && !aw_full_r;
    assign s_wready  = !reset && idle_s && !w_full_r;
    assign s_arready = !reset && rd_win_s;

    assign cpu_wr      = cpu_wr_r;
    assign cpu_rd      = cpu_rd_r;
    assign cpu_wr_addr = cpu_wr_addr_r;
    assign cpu_data_in = cpu_data_in_r;
    assign s_bvalid    = bvalid_r;
    assign s_bresp     = bresp_r;
    assign s_rvalid    = rvalid_r;
    assign s_rdata     = rdata_r;
    assign s_rresp     = 2'b00;

    // Next-state logic with round-robin arbitration in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        wr_win_s    = 1'b0;
        rd_win_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (aw_full_r && w_full_r && (last_was_rd_r || !s_arvalid)) begin
                    wr_win_s    = 1'b1;
                    state_nxt_s = ST_WR;
                end else if (s_arvalid) begin
                    rd_win_s    = 1'b1;
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                state_nxt_s = ST_WRESP;
            end
            ST_WRESP: begin
                if (s_bready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRESP;
                end
            end
            ST_RD: begin
                if (rd_done_s) begin
                    state_nxt_s = ST_RRESP;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RRESP: begin
                if (s_rready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RRESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // One-entry AW and W holders; both are emptied once the write has been issued.
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
            aw_addr_r <= '0;
            w_data_r  <= '0;
            w_strb_r  <= 4'h0;
        end else if (state_r == ST_WR) begin
            aw_full_r <= 1'b0;
            w_full_r  <= 1'b0;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_full_r <= 1'b1;
                aw_addr_r <= s_awaddr[CPU_ADDR_WIDTH+1:2];
            end
            if (s_wvalid && s_wready) begin
                w_full_r <= 1'b1;
                w_data_r <= s_wdata;
                w_strb_r <= s_wstrb;
            end
        end
    end

    // Registered strobes and response valids, derived from the state being entered.
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            cpu_wr_r <= 1'b0;
            cpu_rd_r <= 1'b0;
            bvalid_r <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            cpu_wr_r <= wr_win_s && (w_strb_r == 4'hF);
            cpu_rd_r <= rd_win_s;
            bvalid_r <= (state_nxt_s == ST_WRESP);
            rvalid_r <= (state_nxt_s == ST_RRESP);
        end
    end

    // MPI address/data, arbitration history, read-latency counter and response payloads.
    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            cpu_wr_addr_r <= '0;
            cpu_data_in_r <= '0;
            last_was_rd_r <= 1'b0;
            err_r         <= 1'b0;
            rd_cnt_r      <= 3'd0;
            bresp_r       <= 2'b00;
            rdata_r       <= '0;
        end else begin
            if (wr_win_s) begin
                cpu_wr_addr_r <= aw_addr_r;
                cpu_data_in_r <= w_data_r;
                err_r         <= (w_strb_r != 4'hF);
                last_was_rd_r <= 1'b0;
            end else if (rd_win_s) begin
                cpu_wr_addr_r <= s_araddr[CPU_ADDR_WIDTH+1:2];
                last_was_rd_r <= 1'b1;
                rd_cnt_r      <= 3'd1;
            end else if (state_r == ST_RD) begin
                rd_cnt_r <= rd_cnt_r + 3'd1;
            end
            // Partial-strobe writes are refused and reported as SLVERR.
            if (state_r == ST_WR) begin
                bresp_r <= {err_r, 1'b0};
            end
            if (rd_done_s) begin
                rdata_r <= cpu_data_out;
            end
        end
    end

endmodule
